// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer for a pipeline boundary: a main register drives the outputs and a
// skid register absorbs one entry so that in_ready comes straight from a flop.
module pipe_skid_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // State bits are {skid_valid, main_valid}; 2'b10 is never entered
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_TWO   = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic [1:0]          r_occ;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;

    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_ld_main_in;
    logic                w_ld_main_skid;
    logic                w_ld_skid;
    logic                w_clr_main_ctrl;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_state[0] & out_ready;

    // Next state and register load strobes
    always_comb begin
        w_state_nxt     = r_state;
        w_ld_main_in    = 1'b0;
        w_ld_main_skid  = 1'b0;
        w_ld_skid       = 1'b0;
        w_clr_main_ctrl = 1'b0;
        if (flush) begin
            w_state_nxt     = S_EMPTY;
            w_clr_main_ctrl = 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt  = S_ONE;
                        w_ld_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    case ({w_in_xfer, w_out_xfer})
                        2'b10: begin
                            w_state_nxt = S_TWO;
                            w_ld_skid   = 1'b1;
                        end
                        2'b11: begin
                            w_ld_main_in = 1'b1;
                        end
                        2'b01: begin
                            w_state_nxt     = S_EMPTY;
                            w_clr_main_ctrl = 1'b1;
                        end
                        default: begin
                            w_state_nxt = S_ONE;
                        end
                    endcase
                end
                S_TWO: begin
                    if (w_out_xfer) begin
                        w_state_nxt    = S_ONE;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt     = S_EMPTY;
                    w_clr_main_ctrl = 1'b1;
                end
            endcase
        end
    end

    // State, ready and occupancy flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
            r_occ      <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= ~w_state_nxt[1];
            r_occ      <= 2'(w_state_nxt[0]) + 2'(w_state_nxt[1]);
        end
    end

    // Main ctrl is zeroed whenever main empties, so a bubble carries NOP control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
        end else if (w_ld_main_in) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
        end else if (w_ld_main_skid) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
        end else if (w_clr_main_ctrl) begin
            r_main_ctrl <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_skid_ctrl <= '0;
        end else if (w_ld_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_state[0];
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, async reset sequence and
// randomized traffic checked against a queue-based model.
module tb_pipe_skid_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [23:0] in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [23:0] out_ctrl;
    logic [1:0]  occupancy;

    int n_checks;
    int n_fail;

    pipe_skid_stage #(.DATA_W(32), .CTRL_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic [23:0] c;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_od;
        logic [23:0] e_oc;
        logic [1:0]  e_occ;
        logic        e_ir;
        logic        chk_d;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [23:0] c;
    } ent_t;

    vec_t vecs[15];
    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] d,
                         input logic [23:0] c, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic in_x;
        logic out_x;
        n_checks = 0;
        n_fail   = 0;
        //             fl iv data          ctrl        or ov od            oc          occ  ir chkd
        vecs[0]  = '{1'b0,1'b1,32'h0000_1004,24'h00_0ABC,1'b1,1'b1,32'h0000_1004,24'h00_0ABC,2'd1,1'b1,1'b1};
        vecs[1]  = '{1'b0,1'b0,32'h0,        24'h0,      1'b1,1'b0,32'h0000_1004,24'h0,      2'd0,1'b1,1'b1};
        vecs[2]  = '{1'b0,1'b1,32'hA000_000A,24'h11_1111,1'b0,1'b1,32'hA000_000A,24'h11_1111,2'd1,1'b1,1'b1};
        vecs[3]  = '{1'b0,1'b1,32'hB000_000B,24'h22_2222,1'b0,1'b1,32'hA000_000A,24'h11_1111,2'd2,1'b0,1'b1};
        vecs[4]  = '{1'b0,1'b1,32'hC000_000C,24'h33_3333,1'b0,1'b1,32'hA000_000A,24'h11_1111,2'd2,1'b0,1'b1};
        vecs[5]  = '{1'b0,1'b1,32'hC000_000C,24'h33_3333,1'b1,1'b1,32'hB000_000B,24'h22_2222,2'd1,1'b1,1'b1};
        vecs[6]  = '{1'b0,1'b1,32'hC000_000C,24'h33_3333,1'b1,1'b1,32'hC000_000C,24'h33_3333,2'd1,1'b1,1'b1};
        vecs[7]  = '{1'b0,1'b0,32'h0,        24'h0,      1'b1,1'b0,32'hC000_000C,24'h0,      2'd0,1'b1,1'b1};
        vecs[8]  = '{1'b0,1'b1,32'hD000_000D,24'h44_4444,1'b0,1'b1,32'hD000_000D,24'h44_4444,2'd1,1'b1,1'b1};
        vecs[9]  = '{1'b0,1'b1,32'hE000_000E,24'h55_5555,1'b0,1'b1,32'hD000_000D,24'h44_4444,2'd2,1'b0,1'b1};
        vecs[10] = '{1'b1,1'b1,32'hF000_000F,24'h66_6666,1'b0,1'b0,32'h0,        24'h0,      2'd0,1'b1,1'b0};
        vecs[11] = '{1'b0,1'b0,32'h0,        24'h0,      1'b1,1'b0,32'h0,        24'h0,      2'd0,1'b1,1'b0};
        vecs[12] = '{1'b0,1'b1,32'h1234_5678,24'h77_7777,1'b0,1'b1,32'h1234_5678,24'h77_7777,2'd1,1'b1,1'b1};
        vecs[13] = '{1'b1,1'b1,32'h9ABC_DEF0,24'h88_8888,1'b1,1'b0,32'h0,        24'h0,      2'd0,1'b1,1'b0};
        vecs[14] = '{1'b0,1'b0,32'h0,        24'h0,      1'b1,1'b0,32'h0,        24'h0,      2'd0,1'b1,1'b0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 24'h0, 1'b0);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_out_ctrl",  32'(out_ctrl), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        #10 rst = 1'b0;
        @(negedge clk);

        // Directed table: single pass, back-pressure fill, drain order, flushes
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy);
            tick();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_out_ctrl", i),  32'(out_ctrl),  32'(vecs[i].e_oc));
            chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
            chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            if (vecs[i].chk_d)
                chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
        end

        // Async reset between edges while holding two entries
        drive(1'b0, 1'b1, 32'h5555_0001, 24'h0A_0001, 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'h5555_0002, 24'h0A_0002, 1'b0);
        tick();
        chk("pre_arst_occupancy", 32'(occupancy), 32'd2);
        drive(1'b0, 1'b0, 32'h0, 24'h0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data",  out_data, 32'd0);
        chk("arst_out_ctrl",  32'(out_ctrl), 32'd0);
        chk("arst_occupancy", 32'(occupancy), 32'd0);
        chk("arst_in_ready",  32'(in_ready), 32'd1);
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'h6666_0001, 24'h0B_0001, 1'b0);
        tick();
        chk("post_arst_out_valid", 32'(out_valid), 32'd1);
        chk("post_arst_out_data",  out_data, 32'h6666_0001);
        chk("post_arst_occupancy", 32'(occupancy), 32'd1);
        drive(1'b1, 1'b0, 32'h0, 24'h0, 1'b0);
        tick();
        chk("pre_rnd_occupancy", 32'(occupancy), 32'd0);

        // Randomized traffic against a FIFO model of held entries
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            flush     = ($urandom_range(0, 63) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_ctrl   = 24'($urandom);
            out_ready = (cyc % 2000 < 1000) ? 1'($urandom_range(0, 1))
                                            : ($urandom_range(0, 3) == 0);
            in_x  = in_valid && (q.size() < 2);
            out_x = (q.size() > 0) && out_ready;
            tick();
            if (flush) begin
                q.delete();
            end else begin
                if (out_x) q.delete(0);
                if (in_x)  q.push_back('{d: in_data, c: in_ctrl});
            end
            chk("rnd_occupancy", 32'(occupancy), 32'(q.size()));
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd_in_ready",  32'(in_ready),  32'(q.size() < 2));
            chk("rnd_state_10",  32'({~in_ready, out_valid} == 2'b10), 32'd0);
            if (q.size() > 0) begin
                chk("rnd_out_data", out_data, q[0].d);
                chk("rnd_out_ctrl", 32'(out_ctrl), 32'(q[0].c));
            end else begin
                chk("rnd_bubble_ctrl", 32'(out_ctrl), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
